// File: rtl/combo_lock_ctrl.sv
// Keypad combination-lock controller with a runtime-programmable code,
// consecutive-failure counting and a timed lockout after too many wrong digits.
module combo_lock_ctrl #(
    parameter int                          DIGITS   = 8,
    parameter int                          KEY_W    = 4,
    parameter logic [DIGITS*KEY_W-1:0]     SEQ_INIT = 32'h12345678,
    parameter int                          MAX_FAIL = 3,
    parameter int                          LOCK_CYC = 500,
    localparam int                         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int                         FAIL_W   = $clog2(MAX_FAIL + 1),
    localparam int                         SEQ_W    = DIGITS * KEY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_strb,
    input  logic [KEY_W-1:0]  key_code,
    input  logic              key_start,
    input  logic              key_prog,
    output logic [2:0]        state,
    output logic [IDX_W-1:0]  digit_idx,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic              unlocked,
    output logic              alarm,
    output logic              locked_out,
    output logic [SEQ_W-1:0]  seq_out
);

    localparam int TMR_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
        ALARM   = 3'd3,
        LOCKOUT = 3'd4,
        PROG    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [SEQ_W-1:0]    shadow_q, shadow_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                strb_q;

    logic                press;
    logic                isDigit;
    logic                lastIdx;
    logic [KEY_W-1:0]    storedDigit;
    logic [SEQ_W-1:0]    shadowWr;
    logic [FAIL_W-1:0]   failInc;

    assign press   = key_strb & ~strb_q;
    assign isDigit = ~key_start & ~key_prog;
    assign lastIdx = (idx_q == IDX_W'(DIGITS - 1));
    assign failInc = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);

    // Digit 0 lives in the MSBs; select the expected digit and build the
    // shadow code with the pressed key written at the current position.
    always_comb begin
        storedDigit = '0;
        shadowWr    = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                storedDigit = seq_q[(DIGITS-i)*KEY_W-1 -: KEY_W];
                shadowWr[(DIGITS-i)*KEY_W-1 -: KEY_W] = key_code;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        seq_d    = seq_q;
        shadow_d = shadow_q;
        timer_d  = timer_q;
        case (state_q)
            INIT: begin
                if (press && key_start) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end
            end
            ENTRY: begin
                if (press && key_start) begin
                    idx_d = '0;
                end else if (press && isDigit) begin
                    if (key_code == storedDigit) begin
                        if (lastIdx) begin
                            state_d = OPEN;
                            idx_d   = '0;
                            fail_d  = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d  = '0;
                        fail_d = failInc;
                        if (failInc == FAIL_W'(MAX_FAIL)) begin
                            state_d = LOCKOUT;
                            timer_d = TMR_W'(LOCK_CYC - 1);
                        end else begin
                            state_d = ALARM;
                        end
                    end
                end
            end
            ALARM: begin
                if (press && key_start) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end
            end
            OPEN: begin
                if (press && key_start) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end else if (press && key_prog) begin
                    state_d  = PROG;
                    idx_d    = '0;
                    shadow_d = seq_q;
                end
            end
            PROG: begin
                // The live code only changes once the final digit is entered,
                // so an abort leaves the previous code untouched.
                if (press && key_start) begin
                    state_d = OPEN;
                    idx_d   = '0;
                end else if (press && isDigit) begin
                    shadow_d = shadowWr;
                    if (lastIdx) begin
                        seq_d   = shadowWr;
                        state_d = OPEN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = INIT;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= INIT;
            idx_q    <= '0;
            fail_q   <= '0;
            seq_q    <= SEQ_INIT;
            shadow_q <= SEQ_INIT;
            timer_q  <= '0;
            strb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            seq_q    <= seq_d;
            shadow_q <= shadow_d;
            timer_q  <= timer_d;
            strb_q   <= key_strb;
        end
    end

    assign state      = state_q;
    assign digit_idx  = idx_q;
    assign fail_cnt   = fail_q;
    assign unlocked   = (state_q == OPEN);
    assign alarm      = (state_q == ALARM);
    assign locked_out = (state_q == LOCKOUT);
    assign seq_out    = seq_q;

endmodule
